uc: RTL and testbench
=====================

# uc

Control unit for the single-cycle microcontroller datapath `microc`. It decodes the datapath's 6-bit `opcode` and drives every `microc` select and enable input. It also holds the sequential state the datapath lacks:
- a registered zero flag;
- a skip/annul flag;
- loop-repeat control through the PC2 return register;
- a sticky illegal-opcode flag;
- a retired-instruction counter.

## Interface
- `ICNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: `microc.opcode`, which is `memdata[15:10]` of the current instruction.
- `z` in 1: combinational ALU zero output of the current cycle.
- `s_inc`, `s_rel`, `s_PC`, `s_wePC2` out 1 each: PC path control.
- `s_we3`, `s_WA3`, `s_inm_alu`, `s_io_alu` out 1 each: register-file write path.
- `s_op` out 3: ALU operation.
- `s_io_enable`, `s_io`, `s_inm_rd` out 1 each: I/O port access.
- `zflag` out 1: registered zero flag.
- `err` out 1: sticky illegal-opcode flag.
- `icount` out `ICNT_W`: retired-instruction count.

## Operation
All select outputs are combinational from `opcode`, `zflag` and `annul`.

Default (NOP) output set:
- `s_inc=1`, `s_rel=0`, `s_PC=0`, `s_wePC2=0`, `s_we3=0`, `s_op=000`, `s_io_enable=0`.
- All other selects 0.
- Net effect: PC←PC+1, nothing written.

Every instruction not listed below uses the NOP set.

Opcode map:
- `000ooo` ALU: `s_op=ooo`, `s_we3=1`, `s_WA3=1` (destination `[3:0]`). `zflag` ← `z` at the clock edge.
- `001000` LI: `s_we3=1`, `s_inm_alu=1`, `s_WA3=1`.
- `001001` IN: `s_we3=1`, `s_io_alu=1`, `s_WA3=0` (destination `[7:4]`), `s_io_enable=1`, `s_io=0`.
- `001010` OUTR: `s_io_enable=1`, `s_io=1`, `s_inm_rd=1` (register operand).
- `001011` OUTI: `s_io_enable=1`, `s_io=1`, `s_inm_rd=0` (immediate `[11:4]`).
- `010000` J: `s_inc=0` (absolute target).
- `010001` JZ: `s_inc=0` if `zflag=1`, otherwise NOP.
- `010010` JNZ: `s_inc=0` if `zflag=0`, otherwise NOP.
- `010011` JR: `s_inc=1`, `s_rel=1`.
- `011000` LNK: `s_wePC2=1`, so PC2←PC+1 (the loop start).
- `011001` RPTNZ: `s_PC=1` (PC←PC2) if `zflag=0`, otherwise NOP.
- `011010` SKZ: set `annul` if `zflag=1`.
- `011011` SKNZ: set `annul` if `zflag=0`.
- `111111` NOP.
- Any other opcode: NOP outputs; sets `err`.

Conditional instructions use registered `zflag`, never the live `z`. Only ALU ops update `zflag`.

Annul cycle (`annul=1`):
- Outputs forced to NOP regardless of opcode.
- No `zflag` update, no `err` set, no `icount` increment.
- `annul` clears at the end of the cycle.
- An annulled SKZ/SKNZ does not re-arm `annul`, so there is no chained skipping.

`icount` increments by 1 for every non-annulled instruction, including NOP and illegal opcodes. It wraps modulo 2^`ICNT_W`.

## Timing
- Reset values: `zflag=0`, `annul=0`, `err=0`, `icount=0`.
- While `reset=1`, outputs take the NOP set: no register, PC2 or port writes.
- Reset mid-skip clears `annul`, so the pending skip is lost.
- Zero latency: controls are valid in the same cycle the opcode is presented.
- `zflag`, `annul`, `err` and `icount` update at the rising edge ending that cycle.
- Back-to-back sequences:
  - ALU then JZ sees the new flag.
  - JZ in the same cycle as an ALU op is impossible (one instruction per cycle).
  - SKZ immediately after an ALU op uses that op's `z`.
- `err` stays set until `reset`.

## Structure
- Shared package `microc_pkg`:
  - 6-bit opcode localparams (`OP_ALU` group, `OP_LI`, `OP_IN`, `OP_OUTR`, `OP_OUTI`, `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_JR`, `OP_LNK`, `OP_RPTNZ`, `OP_SKZ`, `OP_SKNZ`, `OP_NOP`);
  - a NOP control-word constant.
- One natural sub-module: `uc_decode`, a combinational `opcode`/`zflag` → control word plus an `illegal` bit.
- The top level holds the flag/annul/err/counter registers and the annul override mux.

## Test plan
- Reset, then `opcode=001000`: `s_we3=1`, `s_inm_alu=1`, `s_WA3=1`, `s_inc=1`. At the next edge `icount=1`, `zflag=0`.
- ALU `000010` with `z=1`, then JZ `010001`: JZ cycle shows `s_inc=0`. Repeat with `z=0`: `s_inc=1`, `s_rel=0`.
- LNK, ALU with `z=0`, RPTNZ: RPTNZ cycle shows `s_PC=1`. After an ALU with `z=1`, RPTNZ shows `s_PC=0`, `s_inc=1`.
- `zflag=1`, SKZ, then OUTR:
  - the OUTR cycle has `s_io_enable=0` and `s_we3=0`;
  - `icount` advances by 1 only for the pair (the SKZ);
  - a following instruction executes normally.
- Opcode `100101`: NOP outputs, `err` rises the next cycle and holds through later legal instructions; `reset` clears it.
- `ICNT_W=4`: issue 17 NOPs from reset → `icount=1` (wrap). Assert `reset` during a pending annul → the next instruction executes unannulled.

Source files
------------

// File: rtl/microc_pkg.sv
// microc_pkg: shared definitions for the microc control unit.
//   - 6-bit opcode encodings for every instruction the unit decodes
//   - ctrl_t: packed bundle of every datapath select/enable
//   - CTRL_NOP: control word for "PC <- PC+1, nothing written"
package microc_pkg;

  // ALU ops occupy the whole 000ooo group; only the top three bits identify it.
  localparam logic [5:0] OP_ALU   = 6'b000000;
  localparam logic [2:0] OP_ALU_G = 3'b000;
  localparam logic [5:0] OP_LI    = 6'b001000;
  localparam logic [5:0] OP_IN    = 6'b001001;
  localparam logic [5:0] OP_OUTR  = 6'b001010;
  localparam logic [5:0] OP_OUTI  = 6'b001011;
  localparam logic [5:0] OP_J     = 6'b010000;
  localparam logic [5:0] OP_JZ    = 6'b010001;
  localparam logic [5:0] OP_JNZ   = 6'b010010;
  localparam logic [5:0] OP_JR    = 6'b010011;
  localparam logic [5:0] OP_LNK   = 6'b011000;
  localparam logic [5:0] OP_RPTNZ = 6'b011001;
  localparam logic [5:0] OP_SKZ   = 6'b011010;
  localparam logic [5:0] OP_SKNZ  = 6'b011011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  typedef struct packed {
    logic       inc;
    logic       rel;
    logic       pc;
    logic       we_pc2;
    logic       we3;
    logic       wa3;
    logic       inm_alu;
    logic       io_alu;
    logic [2:0] op;
    logic       io_enable;
    logic       io;
    logic       inm_rd;
  } ctrl_t;

  // Only inc is set: sequential fetch, no writes anywhere.
  localparam ctrl_t CTRL_NOP = 14'b1_0_0_0_0_0_0_0_000_0_0_0;

  function automatic logic is_alu(input logic [5:0] opc);
    return opc[5:3] == OP_ALU_G;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// uc_decode: combinational instruction decoder.
// Ports:
//   opcode  in  6  current instruction opcode
//   zflag   in  1  registered zero flag (conditionals never use live z)
//   ctrl    out    datapath control word
//   alu     out 1  instruction is an ALU op (zflag should capture z)
//   skip    out 1  skip instruction whose condition holds (arm annul)
//   illegal out 1  opcode is not in the instruction map
module uc_decode
  import microc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zflag,
  output ctrl_t      ctrl,
  output logic       alu,
  output logic       skip,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    alu     = 1'b0;
    skip    = 1'b0;
    illegal = 1'b0;
    if (is_alu(opcode)) begin
      ctrl.op  = opcode[2:0];
      ctrl.we3 = 1'b1;
      ctrl.wa3 = 1'b1;
      alu      = 1'b1;
    end else begin
      case (opcode)
        OP_LI: begin
          ctrl.we3     = 1'b1;
          ctrl.inm_alu = 1'b1;
          ctrl.wa3     = 1'b1;
        end
        OP_IN: begin
          // Destination comes from [7:4], so wa3 stays 0.
          ctrl.we3       = 1'b1;
          ctrl.io_alu    = 1'b1;
          ctrl.io_enable = 1'b1;
        end
        OP_OUTR: begin
          ctrl.io_enable = 1'b1;
          ctrl.io        = 1'b1;
          ctrl.inm_rd    = 1'b1;
        end
        OP_OUTI: begin
          ctrl.io_enable = 1'b1;
          ctrl.io        = 1'b1;
        end
        OP_J:     ctrl.inc = 1'b0;
        OP_JZ:    ctrl.inc = ~zflag;
        OP_JNZ:   ctrl.inc = zflag;
        OP_JR:    ctrl.rel = 1'b1;
        OP_LNK:   ctrl.we_pc2 = 1'b1;
        // PC2 select wins over the incrementer in the datapath, so inc stays 1.
        OP_RPTNZ: ctrl.pc = ~zflag;
        OP_SKZ:   skip = zflag;
        OP_SKNZ:  skip = ~zflag;
        OP_NOP:   ;
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc.sv
// uc: control unit for the microc datapath.
// Decodes opcode into every datapath select and keeps the sequential state:
// registered zero flag, skip/annul flag, sticky illegal-opcode flag and a
// retired-instruction counter.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   opcode[5:0], z                 current opcode, live ALU zero
//   s_inc s_rel s_PC s_wePC2       PC path control
//   s_we3 s_WA3 s_inm_alu s_io_alu register-file write path
//   s_op[2:0]                      ALU operation
//   s_io_enable s_io s_inm_rd      I/O port access
//   zflag, err, icount             registered state
module uc
  import microc_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              z,
  output logic              s_inc,
  output logic              s_rel,
  output logic              s_PC,
  output logic              s_wePC2,
  output logic              s_we3,
  output logic              s_WA3,
  output logic              s_inm_alu,
  output logic              s_io_alu,
  output logic [2:0]        s_op,
  output logic              s_io_enable,
  output logic              s_io,
  output logic              s_inm_rd,
  output logic              zflag,
  output logic              err,
  output logic [ICNT_W-1:0] icount
);

  ctrl_t             dec_ctrl;
  ctrl_t             ctrl;
  logic              dec_alu;
  logic              dec_skip;
  logic              dec_illegal;
  logic              zflag_reg;
  logic              annul_reg;
  logic              err_reg;
  logic [ICNT_W-1:0] icount_reg;

  uc_decode u_decode (
    .opcode  (opcode),
    .zflag   (zflag_reg),
    .ctrl    (dec_ctrl),
    .alu     (dec_alu),
    .skip    (dec_skip),
    .illegal (dec_illegal)
  );

  // Reset and annulled cycles must not write anything in the datapath.
  assign ctrl = (reset || annul_reg) ? CTRL_NOP : dec_ctrl;

  assign s_inc       = ctrl.inc;
  assign s_rel       = ctrl.rel;
  assign s_PC        = ctrl.pc;
  assign s_wePC2     = ctrl.we_pc2;
  assign s_we3       = ctrl.we3;
  assign s_WA3       = ctrl.wa3;
  assign s_inm_alu   = ctrl.inm_alu;
  assign s_io_alu    = ctrl.io_alu;
  assign s_op        = ctrl.op;
  assign s_io_enable = ctrl.io_enable;
  assign s_io        = ctrl.io;
  assign s_inm_rd    = ctrl.inm_rd;

  assign zflag  = zflag_reg;
  assign err    = err_reg;
  assign icount = icount_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      zflag_reg  <= 1'b0;
      annul_reg  <= 1'b0;
      err_reg    <= 1'b0;
      icount_reg <= '0;
    end else if (annul_reg) begin
      // Annulled instruction: no side effects at all, and an annulled skip
      // cannot re-arm, so skipping never chains.
      annul_reg <= 1'b0;
    end else begin
      icount_reg <= icount_reg + ICNT_W'(1);
      annul_reg  <= dec_skip;
      if (dec_alu)     zflag_reg <= z;
      if (dec_illegal) err_reg   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uc.sv
// tb_uc: directed scoreboard bench for uc (ICNT_W=4 so counter wrap is reachable).
// Stimulus pushes the hand-computed expectation for each cycle; a monitor on
// the falling edge pops and compares controls and registered state.
module tb_uc;

  localparam int W = 4;

  // Expected control words, bit order:
  // inc rel pc wePC2 we3 WA3 inm_alu io_alu op[2:0] io_enable io inm_rd
  localparam logic [13:0] E_NOP  = 14'b1_0_0_0_0_0_0_0_000_0_0_0;
  localparam logic [13:0] E_LI   = 14'b1_0_0_0_1_1_1_0_000_0_0_0;
  localparam logic [13:0] E_IN   = 14'b1_0_0_0_1_0_0_1_000_1_0_0;
  localparam logic [13:0] E_OUTR = 14'b1_0_0_0_0_0_0_0_000_1_1_1;
  localparam logic [13:0] E_OUTI = 14'b1_0_0_0_0_0_0_0_000_1_1_0;
  localparam logic [13:0] E_J    = 14'b0_0_0_0_0_0_0_0_000_0_0_0;
  localparam logic [13:0] E_JR   = 14'b1_1_0_0_0_0_0_0_000_0_0_0;
  localparam logic [13:0] E_LNK  = 14'b1_0_0_1_0_0_0_0_000_0_0_0;
  localparam logic [13:0] E_RPT  = 14'b1_0_1_0_0_0_0_0_000_0_0_0;

  function automatic logic [13:0] e_alu(input logic [2:0] op);
    return {8'b1000_1100, op, 3'b000};
  endfunction

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   opcode = 6'b111111;
  logic         z = 1'b0;
  logic         s_inc, s_rel, s_PC, s_wePC2, s_we3, s_WA3, s_inm_alu, s_io_alu;
  logic [2:0]   s_op;
  logic         s_io_enable, s_io, s_inm_rd, zflag, err;
  logic [W-1:0] icount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [13:0]  ctrl;
    logic         zf;
    logic         er;
    logic [W-1:0] ic;
  } exp_t;

  exp_t sb[$];

  uc #(.ICNT_W(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .s_inc(s_inc), .s_rel(s_rel), .s_PC(s_PC), .s_wePC2(s_wePC2),
    .s_we3(s_we3), .s_WA3(s_WA3), .s_inm_alu(s_inm_alu), .s_io_alu(s_io_alu),
    .s_op(s_op), .s_io_enable(s_io_enable), .s_io(s_io), .s_inm_rd(s_inm_rd),
    .zflag(zflag), .err(err), .icount(icount)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs after the rising edge, queue what that cycle must show.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic zin, input logic [13:0] ec, input logic ezf,
                      input logic eer, input logic [W-1:0] eic);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    z      = zin;
    e.name = name; e.ctrl = ec; e.zf = ezf; e.er = eer; e.ic = eic;
    sb.push_back(e);
  endtask

  // Monitor: compare on the falling edge whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = sb.pop_front();
      act = {s_inc, s_rel, s_PC, s_wePC2, s_we3, s_WA3, s_inm_alu, s_io_alu,
             s_op, s_io_enable, s_io, s_inm_rd};
      checks += 4;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl got=%b want=%b", e.name, act, e.ctrl);
      end
      if (zflag !== e.zf) begin
        failures++;
        $display("FAIL %s zflag got=%b want=%b", e.name, zflag, e.zf);
      end
      if (err !== e.er) begin
        failures++;
        $display("FAIL %s err got=%b want=%b", e.name, err, e.er);
      end
      if (icount !== e.ic) begin
        failures++;
        $display("FAIL %s icount got=%0d want=%0d", e.name, icount, e.ic);
      end
      $display("txn %-10s op=%b ctrl=%b zflag=%b err=%b icount=%0d",
               e.name, opcode, act, zflag, err, icount);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    //    name          rst  opcode     z     ctrl       zf  err ic
    step("rst_hold",   1, 6'b001000, 0, E_NOP,       0, 0, 0);
    step("li",         0, 6'b001000, 0, E_LI,        0, 0, 0);
    step("alu_z1",     0, 6'b000010, 1, e_alu(3'd2), 0, 0, 1);
    step("jz_taken",   0, 6'b010001, 0, E_J,         1, 0, 2);
    step("jnz_not",    0, 6'b010010, 0, E_NOP,       1, 0, 3);
    step("alu_z0",     0, 6'b000101, 0, e_alu(3'd5), 1, 0, 4);
    step("jz_not",     0, 6'b010001, 1, E_NOP,       0, 0, 5);
    step("jnz_taken",  0, 6'b010010, 1, E_J,         0, 0, 6);
    step("lnk",        0, 6'b011000, 0, E_LNK,       0, 0, 7);
    step("alu_z0b",    0, 6'b000000, 0, e_alu(3'd0), 0, 0, 8);
    step("rpt_taken",  0, 6'b011001, 1, E_RPT,       0, 0, 9);
    step("alu_z1b",    0, 6'b000111, 1, e_alu(3'd7), 0, 0, 10);
    step("rpt_not",    0, 6'b011001, 0, E_NOP,       1, 0, 11);
    step("skz",        0, 6'b011010, 0, E_NOP,       1, 0, 12);
    step("outr_annul", 0, 6'b001010, 0, E_NOP,       1, 0, 13);
    step("outr",       0, 6'b001010, 0, E_OUTR,      1, 0, 13);
    step("outi",       0, 6'b001011, 0, E_OUTI,      1, 0, 14);
    step("in",         0, 6'b001001, 0, E_IN,        1, 0, 15);
    step("jr_wrap",    0, 6'b010011, 0, E_JR,        1, 0, 0);
    step("sknz_not",   0, 6'b011011, 0, E_NOP,       1, 0, 1);
    step("li2",        0, 6'b001000, 0, E_LI,        1, 0, 2);
    step("skz2",       0, 6'b011010, 0, E_NOP,       1, 0, 3);
    step("skz_annul",  0, 6'b011010, 0, E_NOP,       1, 0, 4);
    step("li_nochain", 0, 6'b001000, 0, E_LI,        1, 0, 4);
    step("skz3",       0, 6'b011010, 0, E_NOP,       1, 0, 5);
    step("alu_annul",  0, 6'b000001, 0, E_NOP,       1, 0, 6);
    step("jz_keep",    0, 6'b010001, 0, E_J,         1, 0, 6);
    step("illegal",    0, 6'b100101, 0, E_NOP,       1, 0, 7);
    step("nop_err",    0, 6'b111111, 0, E_NOP,       1, 1, 8);
    step("li_err",     0, 6'b001000, 0, E_LI,        1, 1, 9);
    step("skz4",       0, 6'b011010, 0, E_NOP,       1, 1, 10);
    step("rst_mid",    1, 6'b001010, 0, E_NOP,       1, 1, 11);
    step("after_rst",  0, 6'b001010, 0, E_OUTR,      0, 0, 0);
    for (int k = 1; k <= 16; k++)
      step("nop_cnt",  0, 6'b111111, 0, E_NOP,       0, 0, W'(k));
    step("wrap_li",    0, 6'b001000, 0, E_LI,        0, 0, 1);
    step("sknz_taken", 0, 6'b011011, 0, E_NOP,       0, 0, 2);
    step("in_annul",   0, 6'b001001, 0, E_NOP,       0, 0, 3);
    step("in2",        0, 6'b001001, 0, E_IN,        0, 0, 3);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
